instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; the ports SHALL be named clk and Reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; low = reset.
- imem_req  out  1  instruction-memory request, held high until accepted.
- imem_addr  out  32  fetch address, word-aligned.
- imem_rdy  in  1  response valid; imem_data is valid in the same cycle.
- imem_data  in  32  returned instruction word.
- br_taken  in  1  redirect/flush, driven by the condition handler.
- br_target  in  32  redirect address.
- id_ready  in  1  IF/ID register load enable; high = consumer accepts the head entry.
- if_valid  out  1  head entry available.
- if_instr  out  32  head instruction word.
- if_pc4  out  32  head entry's fetch address + 4.
- q_count  out  2  prefetch-queue occupancy, 0..2.

Function
REQ-003 The block SHALL hold a 32-bit fetch_pc and a 2-entry FIFO of {pc4[31:0], instr[31:0]}.
REQ-004 The FSM SHALL have three states:
- IDLE: no request outstanding.
- WAIT: request outstanding, response will be kept.
- DROP: request outstanding, response will be discarded.
REQ-005 imem_req SHALL be 1 in WAIT and DROP and 0 in IDLE; imem_addr SHALL equal the address latched when the request was issued and SHALL stay stable until imem_rdy.
REQ-006 At most one request SHALL be outstanding at any time.
REQ-007 IDLE->WAIT SHALL occur when br_taken=0 and free slots (2 − q_count + pops this cycle) ≥ 1; the latched address SHALL be fetch_pc.
REQ-008 In WAIT with imem_rdy=1 and br_taken=0, the block SHALL:
- push {imem_addr+4, imem_data};
- set fetch_pc <= imem_addr+4;
- go to IDLE.
REQ-009 Pop SHALL occur when if_valid=1 and id_ready=1; the head SHALL advance one entry.
REQ-010 Push and pop in the same cycle SHALL leave q_count unchanged; a push SHALL never occur with q_count=2.
REQ-011 if_valid SHALL be (q_count≠0); if_instr and if_pc4 SHALL show the head entry combinationally, and SHALL be 0 when the queue is empty.
REQ-012 br_taken=1 SHALL take priority over push and pop in the same cycle:
- queue cleared (q_count <= 0);
- fetch_pc <= {br_target[31:2],2'b00}.
REQ-013 br_taken=1 SHALL move the FSM as follows:
- WAIT with imem_rdy=0 -> DROP;
- WAIT with imem_rdy=1 -> IDLE, response discarded;
- IDLE -> stays IDLE, no request that cycle;
- DROP -> stays DROP, fetch_pc updated to the new target.
REQ-014 In DROP, imem_rdy=1 with br_taken=0 SHALL discard imem_data and move to IDLE; fetch_pc SHALL be unchanged.
REQ-015 All address arithmetic SHALL be modulo 2^32: 0xFFFFFFFC+4 = 0x00000000.
REQ-016 Latency: a response accepted at edge N SHALL give if_valid=1 after edge N; with imem_rdy tied high and id_ready=1, sustained throughput SHALL be one instruction per 2 cycles.

Reset
REQ-017 While Reset=0, regardless of clk, the block SHALL force:
- fetch_pc=0; queue empty; q_count=0; FSM=IDLE;
- imem_req=0, imem_addr=0, if_valid=0, if_instr=0, if_pc4=0.
REQ-018 Reset asserted mid-request SHALL abandon the outstanding request; any later imem_rdy SHALL be ignored while in IDLE.
REQ-019 After Reset deasserts, the first request SHALL go out at address 0 on the first rising edge.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Reset, imem_rdy=1 constant, id_ready=1, memory word[n]=n -> if_instr sequence 0,1,2,… with if_pc4 = 4,8,12,…, one new entry every 2 cycles.
- id_ready=0 for 10 cycles -> exactly 2 entries (addresses 0, 4) queued, q_count=2, imem_req=0; release id_ready -> entries pop in order, then fetching resumes at 8.
- imem_rdy delayed 3 cycles; br_taken=1 with br_target=0x40 during WAIT -> FSM goes to DROP, the late word is discarded, the next request is at 0x40 and the first valid if_pc4=0x44.
- br_taken=1 in the same cycle as push and pop with q_count=1 -> q_count=0 next cycle, no stale entry delivered.
- br_target=0x00000043 -> fetch at 0x40; br_target=0xFFFFFFFC -> if_pc4=0x00000000.
- Reset pulsed low while in WAIT -> all outputs 0 immediately; after release, fetch restarts at address 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requester feeding a
// 2-entry prefetch queue of {pc+4, instr}, with branch redirect/flush.
module instr_fetch_unit (
  input  logic        clk,
  input  logic        Reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_data,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc4,
  output logic [1:0]  q_count,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] req_addr, req_addr_nxt;
  logic [31:0] q_pc4   [2];
  logic [31:0] q_instr [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        push, pop, has_slot;
  logic [31:0] resp_pc4;

  // Handshake: imem_req stays high with imem_addr stable until imem_rdy is
  // seen at a rising edge; a pop happens whenever if_valid && id_ready.
  assign pop      = if_valid & id_ready;
  assign has_slot = (count != 2'd2) | pop;
  assign resp_pc4 = req_addr + 32'd4;

  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    req_addr_nxt = req_addr;
    push         = 1'b0;
    case (state)
      S_IDLE: begin
        if (!br_taken && has_slot) begin
          state_nxt    = S_WAIT;
          req_addr_nxt = fetch_pc;
        end
      end
      S_WAIT: begin
        if (imem_rdy) begin
          state_nxt = S_IDLE;
          if (!br_taken) begin
            push         = 1'b1;
            fetch_pc_nxt = resp_pc4;
          end
        end else if (br_taken) begin
          state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rdy && !br_taken) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // A redirect always wins over the sequential next fetch address.
    if (br_taken) fetch_pc_nxt = {br_target[31:2], 2'b00};
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      fetch_pc <= 32'd0;
      req_addr <= 32'd0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      req_addr <= req_addr_nxt;
    end
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        q_pc4[i]   <= 32'd0;
        q_instr[i] <= 32'd0;
      end
    end else if (br_taken) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
    end else begin
      if (push) begin
        q_pc4[wr_ptr]   <= resp_pc4;
        q_instr[wr_ptr] <= imem_data;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign imem_req  = (state != S_IDLE);
  assign imem_addr = req_addr;
  assign if_valid  = (count != 2'd0);
  assign if_instr  = if_valid ? q_instr[rd_ptr] : 32'd0;
  assign if_pc4    = if_valid ? q_pc4[rd_ptr] : 32'd0;
  assign q_count   = count;
  assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: memory model returns word[n]=n for
// address 4n after a programmable delay; each scenario checks inline.
module tb_instr_fetch_unit;

  logic        clk;
  logic        Reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic [1:0]  q_count;
  logic [1:0]  dbg_state;

  int tests = 0;
  int fails = 0;
  int mem_delay = 0;
  int wait_cnt = 0;

  instr_fetch_unit dut (
    .clk       (clk),
    .Reset     (Reset),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_rdy  (imem_rdy),
    .imem_data (imem_data),
    .br_taken  (br_taken),
    .br_target (br_target),
    .id_ready  (id_ready),
    .if_valid  (if_valid),
    .if_instr  (if_instr),
    .if_pc4    (if_pc4),
    .q_count   (q_count),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory responder, updated on the falling edge
  initial begin
    imem_rdy  = 1'b0;
    imem_data = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req) begin
        if (wait_cnt >= mem_delay) begin
          imem_rdy  = 1'b1;
          imem_data = imem_addr >> 2;
        end else begin
          imem_rdy = 1'b0;
          wait_cnt++;
        end
      end else begin
        imem_rdy = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
  endtask

  task automatic test_reset();
    Reset = 1'b0; id_ready = 1'b1; br_taken = 1'b0; br_target = 32'd0; mem_delay = 0;
    #3;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL rst_req got %h exp 0", imem_req); end
    tests++; if (imem_addr !== 32'd0) begin fails++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %h exp 0", if_valid); end
    tests++; if (if_instr !== 32'd0 || if_pc4 !== 32'd0) begin fails++; $display("FAIL rst_head got %h/%h exp 0/0", if_instr, if_pc4); end
    tests++; if (q_count !== 2'd0) begin fails++; $display("FAIL rst_count got %0d exp 0", q_count); end
    do_reset();
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL rst_first_req got %h@%h exp 1@0", imem_req, imem_addr); end
    tests++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL rst_first_state got %0d exp 1", dbg_state); end
  endtask

  task automatic test_stream();
    mem_delay = 0; id_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      tick();
      tests++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) begin fails++; $display("FAIL stream_req[%0d] got %h@%h exp 1@%h", k, imem_req, imem_addr, 4 * k); end
      tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL stream_gap[%0d] got %h exp 0", k, if_valid); end
      tick();
      tests++; if (if_valid !== 1'b1 || if_instr !== 32'(k) || if_pc4 !== 32'(4 * k + 4)) begin fails++; $display("FAIL stream_head[%0d] got v%h %h/%h exp v1 %h/%h", k, if_valid, if_instr, if_pc4, k, 4 * k + 4); end
    end
  endtask

  task automatic test_stall();
    mem_delay = 0; id_ready = 1'b0;
    do_reset();
    repeat (10) tick();
    tests++; if (q_count !== 2'd2) begin fails++; $display("FAIL stall_count got %0d exp 2", q_count); end
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL stall_req got %h exp 0", imem_req); end
    tests++; if (if_instr !== 32'd0 || if_pc4 !== 32'd4) begin fails++; $display("FAIL stall_head got %h/%h exp 0/4", if_instr, if_pc4); end
    id_ready = 1'b1;
    tick();
    tests++; if (if_instr !== 32'd1 || if_pc4 !== 32'd8 || q_count !== 2'd1) begin fails++; $display("FAIL stall_pop1 got %h/%h c%0d exp 1/8 c1", if_instr, if_pc4, q_count); end
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin fails++; $display("FAIL stall_resume got %h@%h exp 1@8", imem_req, imem_addr); end
    tick();
    tests++; if (if_instr !== 32'd2 || if_pc4 !== 32'd12 || q_count !== 2'd1) begin fails++; $display("FAIL stall_pushpop got %h/%h c%0d exp 2/c c1", if_instr, if_pc4, q_count); end
  endtask

  task automatic test_drop();
    mem_delay = 3; id_ready = 1'b1;
    do_reset();
    tick();
    br_taken = 1'b1; br_target = 32'h40;
    tick();
    br_taken = 1'b0;
    tests++; if (dbg_state !== 2'd2 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL drop_enter got s%0d %h@%h exp s2 1@0", dbg_state, imem_req, imem_addr); end
    tick(); tick();
    tests++; if (dbg_state !== 2'd2) begin fails++; $display("FAIL drop_hold got %0d exp 2", dbg_state); end
    tick();
    tests++; if (dbg_state !== 2'd0 || if_valid !== 1'b0 || q_count !== 2'd0) begin fails++; $display("FAIL drop_discard got s%0d v%h c%0d exp s0 v0 c0", dbg_state, if_valid, q_count); end
    mem_delay = 0;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin fails++; $display("FAIL drop_redirect got %h@%h exp 1@40", imem_req, imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc4 !== 32'h44 || if_instr !== 32'h10) begin fails++; $display("FAIL drop_first got v%h %h/%h exp v1 10/44", if_valid, if_instr, if_pc4); end
  endtask

  task automatic test_flush();
    mem_delay = 0; id_ready = 1'b0;
    do_reset();
    tick(); tick();
    tests++; if (q_count !== 2'd1) begin fails++; $display("FAIL flush_pre_count got %0d exp 1", q_count); end
    tick();
    tests++; if (dbg_state !== 2'd1 || imem_addr !== 32'd4) begin fails++; $display("FAIL flush_pre_req got s%0d @%h exp s1 @4", dbg_state, imem_addr); end
    id_ready = 1'b1; br_taken = 1'b1; br_target = 32'h80;
    tick();
    br_taken = 1'b0;
    tests++; if (q_count !== 2'd0 || if_valid !== 1'b0 || if_instr !== 32'd0) begin fails++; $display("FAIL flush_clear got c%0d v%h %h exp c0 v0 0", q_count, if_valid, if_instr); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin fails++; $display("FAIL flush_redirect got %h@%h exp 1@80", imem_req, imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc4 !== 32'h84 || if_instr !== 32'h20) begin fails++; $display("FAIL flush_first got v%h %h/%h exp v1 20/84", if_valid, if_instr, if_pc4); end
  endtask

  task automatic test_align();
    mem_delay = 0; id_ready = 1'b1;
    do_reset();
    br_taken = 1'b1; br_target = 32'h43;
    tick();
    br_taken = 1'b0;
    tests++; if (imem_req !== 1'b0) begin fails++; $display("FAIL align_idle got %h exp 0", imem_req); end
    tick();
    tests++; if (imem_addr !== 32'h40) begin fails++; $display("FAIL align_addr got %h exp 40", imem_addr); end
    tick();
    tests++; if (if_pc4 !== 32'h44 || if_instr !== 32'h10) begin fails++; $display("FAIL align_head got %h/%h exp 10/44", if_instr, if_pc4); end
    br_taken = 1'b1; br_target = 32'hFFFF_FFFC;
    tick();
    br_taken = 1'b0;
    tests++; if (q_count !== 2'd0 || imem_req !== 1'b0) begin fails++; $display("FAIL align_flush got c%0d r%h exp c0 r0", q_count, imem_req); end
    tick();
    tests++; if (imem_addr !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_pc4 !== 32'd0 || if_instr !== 32'h3FFF_FFFF) begin fails++; $display("FAIL wrap_head got v%h %h/%h exp v1 3fffffff/0", if_valid, if_instr, if_pc4); end
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL wrap_next got %h@%h exp 1@0", imem_req, imem_addr); end
  endtask

  task automatic test_reset_mid();
    mem_delay = 3; id_ready = 1'b1;
    do_reset();
    tick(); tick();
    tests++; if (dbg_state !== 2'd1) begin fails++; $display("FAIL midrst_pre got %0d exp 1", dbg_state); end
    #2;
    Reset = 1'b0;
    #1;
    tests++; if (imem_req !== 1'b0 || imem_addr !== 32'd0 || dbg_state !== 2'd0) begin fails++; $display("FAIL midrst_req got %h@%h s%0d exp 0@0 s0", imem_req, imem_addr, dbg_state); end
    tests++; if (if_valid !== 1'b0 || if_instr !== 32'd0 || if_pc4 !== 32'd0 || q_count !== 2'd0) begin fails++; $display("FAIL midrst_q got v%h %h/%h c%0d exp all 0", if_valid, if_instr, if_pc4, q_count); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    Reset = 1'b1;
    mem_delay = 0;
    tick();
    tests++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin fails++; $display("FAIL midrst_restart got %h@%h exp 1@0", imem_req, imem_addr); end
    tick();
    tests++; if (if_valid !== 1'b1 || if_instr !== 32'd0 || if_pc4 !== 32'd4) begin fails++; $display("FAIL midrst_first got v%h %h/%h exp v1 0/4", if_valid, if_instr, if_pc4); end
  endtask

  initial begin
    Reset = 1'b0; id_ready = 1'b1; br_taken = 1'b0; br_target = 32'd0;
    test_reset();
    test_stream();
    test_stall();
    test_drop();
    test_flush();
    test_align();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
